// File: rtl/uart_pkg.sv
// Shared UART definitions: register offsets, STATUS bit positions, FSM states.
`timescale 1ns/1ps
package uart_pkg;

    localparam logic [3:0] UART_DATA   = 4'h0;
    localparam logic [3:0] UART_STATUS = 4'h4;
    localparam logic [3:0] UART_DIV    = 4'h8;

    localparam int unsigned ST_TX_FULL   = 0;
    localparam int unsigned ST_TX_EMPTY  = 1;
    localparam int unsigned ST_RX_VALID  = 2;
    localparam int unsigned ST_RX_OVERUN = 3;
    localparam int unsigned ST_TX_BUSY   = 4;
    localparam int unsigned ST_FRAME_ERR = 5;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    // A divider of zero would stall the bit counters, so it behaves as one.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/bus_if.sv
// Simple register bus: independent read and write channels, 1-cycle read latency.
`timescale 1ns/1ps
interface bus_if;
    logic [31:0] raddr;
    logic        ren;
    logic [31:0] rdata;
    logic [31:0] waddr;
    logic        wen;
    logic [3:0]  bytemask;
    logic [31:0] wdata;

    modport master (output raddr, ren, waddr, wen, bytemask, wdata, input rdata);
    modport slave  (input raddr, ren, waddr, wen, bytemask, wdata, output rdata);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head; push on full succeeds when a pop happens in the same cycle.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign empty     = (r_wptr == r_rptr);
    assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);
    assign head      = r_mem[r_rptr[AW-1:0]];

    // Pointer update; extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop_ok)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART: register decode, TX/RX FIFOs, bit-timing and both line FSMs.
`timescale 1ns/1ps
module uart_periph
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic  clk,
    input  logic  rst,
    bus_if.slave  bus,
    output logic  txd,
    input  logic  rxd
);
    logic [15:0] r_div;
    logic [15:0] w_div;
    logic        r_overrun;
    logic        r_frame_err;
    logic [31:0] w_status;

    logic w_rd_data, w_rd_status, w_wr_data, w_wr_div;
    logic w_tx_full, w_tx_empty, w_tx_pop;
    logic [7:0] w_tx_head;
    logic w_rx_full, w_rx_empty, w_rx_pop, w_rx_push;
    logic [7:0] w_rx_head;
    logic w_frame_set, w_ovr_set;
    logic w_unused;

    uart_state_t r_tx_state;
    logic [15:0] r_tx_cnt;
    logic [7:0]  r_tx_shift;
    logic [2:0]  r_tx_idx;

    uart_state_t r_rx_state;
    logic [15:0] r_rx_cnt;
    logic [7:0]  r_rx_shift;
    logic [2:0]  r_rx_idx;
    logic        r_rx_s1, r_rx_s2, r_rx_prev;

    assign w_div       = eff_div(r_div);
    assign w_rd_data   = bus.ren && (bus.raddr[3:2] == UART_DATA[3:2]);
    assign w_rd_status = bus.ren && (bus.raddr[3:2] == UART_STATUS[3:2]);
    assign w_wr_data   = bus.wen && (bus.waddr[3:2] == UART_DATA[3:2]) && bus.bytemask[0];
    assign w_wr_div    = bus.wen && (bus.waddr[3:2] == UART_DIV[3:2]);
    assign w_unused    = ^{bus.raddr[31:4], bus.raddr[1:0], bus.waddr[31:4], bus.waddr[1:0],
                           bus.wdata[31:16], bus.bytemask[3:2]};

    assign w_tx_pop    = !w_tx_empty &&
                         ((r_tx_state == IDLE) || (r_tx_state == STOP && r_tx_cnt == 16'd0));
    assign w_rx_pop    = w_rd_data && !w_rx_empty;
    assign w_rx_push   = (r_rx_state == STOP) && (r_rx_cnt == 16'd0) && r_rx_s2;
    assign w_frame_set = (r_rx_state == STOP) && (r_rx_cnt == 16'd0) && !r_rx_s2;
    assign w_ovr_set   = w_rx_push && w_rx_full && !w_rx_pop;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(w_wr_data), .din(bus.wdata[7:0]), .pop(w_tx_pop),
        .full(w_tx_full), .empty(w_tx_empty), .head(w_tx_head)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(w_rx_push), .din(r_rx_shift), .pop(w_rx_pop),
        .full(w_rx_full), .empty(w_rx_empty), .head(w_rx_head)
    );

    // STATUS word assembly.
    always_comb begin
        w_status               = '0;
        w_status[ST_TX_FULL]   = w_tx_full;
        w_status[ST_TX_EMPTY]  = w_tx_empty;
        w_status[ST_RX_VALID]  = !w_rx_empty;
        w_status[ST_RX_OVERUN] = r_overrun;
        w_status[ST_TX_BUSY]   = (r_tx_state != IDLE);
        w_status[ST_FRAME_ERR] = r_frame_err;
    end

    // Register reads, DIV writes and sticky flags; a set in the clearing cycle wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div       <= DIV_RESET;
            bus.rdata   <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (bus.ren) begin
                case (bus.raddr[3:2])
                    UART_DATA[3:2]:   bus.rdata <= w_rx_empty ? 32'd0 : {24'd0, w_rx_head};
                    UART_STATUS[3:2]: bus.rdata <= w_status;
                    UART_DIV[3:2]:    bus.rdata <= {16'd0, r_div};
                    default:          bus.rdata <= '0;
                endcase
            end
            if (w_wr_div && bus.bytemask[0]) r_div[7:0]  <= bus.wdata[7:0];
            if (w_wr_div && bus.bytemask[1]) r_div[15:8] <= bus.wdata[15:8];
            r_overrun   <= w_ovr_set   || (r_overrun   && !w_rd_status);
            r_frame_err <= w_frame_set || (r_frame_err && !w_rd_status);
        end
    end

    // TX FSM: each bit held for the divider sampled at its start; STOP chains straight into START.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= IDLE;
            r_tx_cnt   <= '0;
            r_tx_shift <= '0;
            r_tx_idx   <= '0;
            txd        <= 1'b1;
        end else begin
            case (r_tx_state)
                IDLE: if (!w_tx_empty) begin
                    r_tx_state <= START;
                    r_tx_shift <= w_tx_head;
                    r_tx_cnt   <= w_div - 16'd1;
                    txd        <= 1'b0;
                end
                START: if (r_tx_cnt == 16'd0) begin
                    r_tx_state <= DATA;
                    txd        <= r_tx_shift[0];
                    r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                    r_tx_idx   <= '0;
                    r_tx_cnt   <= w_div - 16'd1;
                end else r_tx_cnt <= r_tx_cnt - 16'd1;
                DATA: if (r_tx_cnt == 16'd0) begin
                    r_tx_cnt <= w_div - 16'd1;
                    if (r_tx_idx == 3'd7) begin
                        r_tx_state <= STOP;
                        txd        <= 1'b1;
                    end else begin
                        txd        <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_idx   <= r_tx_idx + 3'd1;
                    end
                end else r_tx_cnt <= r_tx_cnt - 16'd1;
                STOP: if (r_tx_cnt == 16'd0) begin
                    if (!w_tx_empty) begin
                        r_tx_state <= START;
                        r_tx_shift <= w_tx_head;
                        r_tx_cnt   <= w_div - 16'd1;
                        txd        <= 1'b0;
                    end else r_tx_state <= IDLE;
                end else r_tx_cnt <= r_tx_cnt - 16'd1;
                default: r_tx_state <= IDLE;
            endcase
        end
    end

    // RX synchroniser and FSM: mid-bit sampling; push and frame error are decoded from the STOP sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= IDLE;
            r_rx_cnt   <= '0;
            r_rx_shift <= '0;
            r_rx_idx   <= '0;
        end else begin
            r_rx_s1   <= rxd;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            case (r_rx_state)
                IDLE: if (r_rx_prev && !r_rx_s2) begin
                    r_rx_state <= START;
                    r_rx_cnt   <= w_div >> 1;
                end
                START: if (r_rx_cnt == 16'd0) begin
                    if (r_rx_s2) r_rx_state <= IDLE;
                    else begin
                        r_rx_state <= DATA;
                        r_rx_idx   <= '0;
                        r_rx_cnt   <= w_div - 16'd1;
                    end
                end else r_rx_cnt <= r_rx_cnt - 16'd1;
                DATA: if (r_rx_cnt == 16'd0) begin
                    r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                    r_rx_cnt   <= w_div - 16'd1;
                    if (r_rx_idx == 3'd7) r_rx_state <= STOP;
                    else r_rx_idx <= r_rx_idx + 3'd1;
                end else r_rx_cnt <= r_rx_cnt - 16'd1;
                STOP: if (r_rx_cnt == 16'd0) r_rx_state <= IDLE;
                      else r_rx_cnt <= r_rx_cnt - 16'd1;
                default: r_rx_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_periph.sv
// Randomized self-checking bench for uart_periph against a queue-based UART model.
`timescale 1ns/1ps
module tb_uart_periph;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    logic txd;

    bus_if bus_i();

    uart_periph #(.FIFO_DEPTH(8), .DIV_RESET(16'd868)) dut (
        .clk(clk), .rst(rst), .bus(bus_i), .txd(txd), .rxd(rxd)
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [7:0]  tx_exp[$];
    logic [7:0]  rx_q[$];
    logic        m_ovr  = 1'b0;
    logic        m_ferr = 1'b0;
    bit          mon_en = 1'b0;
    int unsigned mon_div = 868;

    localparam logic [3:0] OFF_DATA = 4'h0, OFF_STAT = 4'h4, OFF_DIV = 4'h8, OFF_RSV = 4'hC;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Region 2 address with random don't-care bits outside [3:2].
    function automatic logic [31:0] addr(input logic [3:0] off);
        return 32'h2000_0000 | ($urandom & 32'h0FFF_FFF3) | {28'd0, off};
    endfunction

    task automatic wr(input logic [3:0] off, input logic [3:0] mask, input logic [31:0] d);
        @(negedge clk);
        bus_i.waddr = addr(off); bus_i.bytemask = mask; bus_i.wdata = d; bus_i.wen = 1'b1;
        @(negedge clk);
        bus_i.wen = 1'b0;
    endtask

    task automatic rd(input logic [3:0] off, output logic [31:0] d);
        @(negedge clk);
        bus_i.raddr = addr(off); bus_i.ren = 1'b1;
        @(negedge clk);
        bus_i.ren = 1'b0;
        d = bus_i.rdata;
    endtask

    task automatic set_div(input logic [15:0] d);
        wr(OFF_DIV, 4'b0011, {16'd0, d});
        mon_div = (d == 16'd0) ? 1 : int'(d);
    endtask

    function automatic logic [31:0] exp_status(input logic busy, input logic txe, input logic txf);
        return {26'd0, m_ferr, busy, m_ovr, rx_q.size() != 0, txe, txf};
    endfunction

    task automatic rd_status(input string tag, input logic busy, input logic txe, input logic txf);
        logic [31:0] s;
        rd(OFF_STAT, s);
        check(tag, s, exp_status(busy, txe, txf));
        m_ovr = 1'b0; m_ferr = 1'b0;
    endtask

    task automatic rd_data(input string tag);
        logic [31:0] d, e;
        rd(OFF_DATA, d);
        e = (rx_q.size() != 0) ? {24'd0, rx_q.pop_front()} : 32'd0;
        check(tag, d, e);
    endtask

    // Drive one 8N1 frame on rxd, then idle long enough for the byte to land.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int unsigned d);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); rxd = fr[k];
            repeat (d - 1) @(negedge clk);
        end
        @(negedge clk); rxd = 1'b1;
        repeat (8) @(negedge clk);
        if (!stop_bit) m_ferr = 1'b1;
        else if (rx_q.size() < 8) rx_q.push_back(b);
        else m_ovr = 1'b1;
    endtask

    task automatic wait_tx_idle(input string tag);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < 5000; i++) begin
            rd(OFF_STAT, s);
            m_ovr = 1'b0; m_ferr = 1'b0;
            if (s[1] && !s[4]) break;
        end
        check(tag, {30'd0, s[4], s[1]}, 32'd1);
    endtask

    // Line monitor: decodes txd frames at mid-bit and matches them against queued bytes.
    initial begin
        logic prev, st0, stp;
        logic [7:0] b;
        int unsigned d;
        wait (mon_en);
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !txd) begin
                d = mon_div;
                repeat (d / 2) @(negedge clk);
                st0 = txd;
                for (int k = 0; k < 8; k++) begin
                    repeat (d) @(negedge clk);
                    b[k] = txd;
                end
                repeat (d) @(negedge clk);
                stp = txd;
                if (mon_en) begin
                    check("tx_start_bit", {31'd0, st0}, 32'd0);
                    check("tx_stop_bit", {31'd0, stp}, 32'd1);
                    check("tx_byte", {24'd0, b}, (tx_exp.size() != 0) ? {24'd0, tx_exp.pop_front()} : 32'h100);
                end
                prev = txd;
            end else prev = txd;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [9:0]  frame;
        logic [7:0]  b;
        int unsigned lat, d;
        int unsigned divs[6] = '{0, 1, 2, 3, 5, 7};

        bus_i.raddr = '0; bus_i.ren = 1'b0; bus_i.waddr = '0; bus_i.wen = 1'b0;
        bus_i.bytemask = '0; bus_i.wdata = '0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // Reset state and register map.
        check("rst_txd", {31'd0, txd}, 32'd1);
        rd_status("rst_status", 1'b0, 1'b1, 1'b0);
        rd(OFF_DIV, v);  check("rst_div", v, 32'd868);
        rd(OFF_DATA, v); check("rst_data_empty", v, 32'd0);
        wr(OFF_DIV, 4'b0010, 32'h1234_AB56);
        rd(OFF_DIV, v);  check("div_hi_byte", v, 32'h0000_AB64);
        wr(OFF_RSV, 4'b1111, 32'hFFFF_FFFF);
        rd(OFF_RSV, v);  check("rsv_read", v, 32'd0);
        rd_status("rsv_no_push", 1'b0, 1'b1, 1'b0);

        // Exact waveform of 0x55 at DIV=4.
        set_div(16'd4);
        tx_exp.push_back(8'h55);
        wr(OFF_DATA, 4'b0001, 32'h0000_0055);
        lat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            lat = i;
            if (txd == 1'b0) break;
        end
        check("tx_fall_le2", {31'd0, lat <= 2}, 32'd1);
        frame = {1'b1, 8'h55, 1'b0};
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            check("tx55_wave", {31'd0, txd}, {31'd0, frame[c / 4]});
        end
        rd_status("tx55_done", 1'b0, 1'b1, 1'b0);

        // Fill TX FIFO: one byte in the shifter, eight queued, the tenth dropped.
        d = $urandom_range(60, 30);
        set_div(16'(d));
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            if (i < 9) tx_exp.push_back(b);
            wr(OFF_DATA, 4'b0001, {24'd0, b});
        end
        rd_status("tx_full_status", 1'b1, 1'b0, 1'b1);
        wait_tx_idle("tx9_drain");
        check("tx9_pending", tx_exp.size(), 32'd0);

        // Random short bursts over small dividers, including zero.
        foreach (divs[j]) begin
            set_div(16'(divs[j]));
            for (int i = 0; i < 3; i++) begin
                b = 8'($urandom);
                tx_exp.push_back(b);
                wr(OFF_DATA, 4'b0001, {24'd0, b});
            end
            wait_tx_idle("txr_drain");
            check("txr_pending", tx_exp.size(), 32'd0);
        end

        // RX 0xA3 at DIV=8.
        set_div(16'd8);
        send_rx(8'hA3, 1'b1, 8);
        rd_status("a3_status", 1'b0, 1'b1, 1'b0);
        rd_data("a3_data");
        rd_data("a3_empty_read");
        rd_status("a3_after", 1'b0, 1'b1, 1'b0);

        // Random RX bytes at random dividers.
        for (int i = 0; i < 4; i++) begin
            d = $urandom_range(16, 8);
            set_div(16'(d));
            send_rx(8'($urandom), 1'b1, d);
            rd_status("rxr_status", 1'b0, 1'b1, 1'b0);
            rd_data("rxr_data");
        end

        // Overrun: nine frames without reads.
        set_div(16'd8);
        for (int i = 0; i < 9; i++) send_rx(8'($urandom), 1'b1, 8);
        rd_status("ovr_status", 1'b0, 1'b1, 1'b0);
        rd_status("ovr_cleared", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) rd_data("ovr_drain");
        rd_data("ovr_empty");

        // Framing error, then recovery with a good frame.
        send_rx(8'($urandom), 1'b0, 8);
        rd_status("ferr_status", 1'b0, 1'b1, 1'b0);
        rd_status("ferr_cleared", 1'b0, 1'b1, 1'b0);
        send_rx(8'($urandom), 1'b1, 8);
        rd_data("ferr_recover");

        // Reset mid TX frame with data pending in both FIFOs.
        send_rx(8'($urandom), 1'b1, 8);
        mon_en = 1'b0;
        wr(OFF_DATA, 4'b0001, 32'h0000_00C3);
        wr(OFF_DATA, 4'b0001, 32'h0000_003C);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_txd", {31'd0, txd}, 32'd1);
        rst = 1'b0;
        rx_q.delete(); tx_exp.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
        rd_status("rst_mid_status", 1'b0, 1'b1, 1'b0);
        rd(OFF_DIV, v); check("rst_mid_div", v, 32'd868);
        rd_data("rst_mid_rx_empty");
        repeat (100) @(negedge clk);
        check("rst_mid_txd_idle", {31'd0, txd}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_periph.md
# uart_periph

Memory-mapped UART peripheral: the bus responder in the UART address region (bits [31:28] = 2). It sits behind the system bus controller on a `bus_if.slave` port, which is the responder end of the controller's `bus_if.master` UART port. It accepts register reads and writes, serialises bytes from a TX FIFO onto `txd` as 8N1, and deserialises `rxd` into an RX FIFO.

## Interface
- `FIFO_DEPTH`, default 8: entries per TX and RX FIFO; must be a power of 2, ≥2.
- `DIV_RESET`, default 16'd868: reset value of the DIV register (clocks per bit).
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `bus`  bus_if.slave  —  fields `raddr`, `ren`, `rdata`, `waddr`, `wen`, `bytemask`, `wdata`.
- `txd`  out  1  serial transmit; idle high.
- `rxd`  in  1  serial receive; asynchronous, idle high.

## Operation
- Decode uses address offset bits [3:2] only; bits [27:4] and [1:0] are ignored.
- 0x0 DATA:
  - Write with `bytemask[0]=1` pushes `wdata[7:0]` into the TX FIFO. If the TX FIFO is full, the byte is dropped silently.
  - Read returns `{24'b0, rx_head}` and pops the RX FIFO. If the RX FIFO is empty, the read returns 0 and nothing is popped.
- 0x4 STATUS (read-only):
  - bit0 `tx_full`, bit1 `tx_empty`, bit2 `rx_valid`, bit3 `rx_overrun`, bit4 `tx_busy`, bit5 `frame_err`; other bits 0.
  - bits 3 and 5 are sticky and are cleared by a STATUS read.
- 0x8 DIV (read/write): 16-bit clocks-per-bit. `bytemask[0]` writes [7:0]; `bytemask[1]` writes [15:8]. A value of 0 is treated as 1.
- 0xC: reads return 0; writes are ignored.
- TX FSM (IDLE→START→DATA→STOP→IDLE):
  - Leaves IDLE when the TX FIFO is non-empty, popping one byte on exit.
  - Each bit is held for DIV clocks; data is sent LSB first; the stop bit is 1.
  - From STOP, goes directly to START if the FIFO is non-empty, giving back-to-back frames with no idle gap.
- RX path:
  - `rxd` passes through a 2-flop synchroniser.
  - FSM IDLE→START→DATA→STOP. A falling edge in IDLE enters START.
  - START samples at DIV/2; if the sample is high (glitch), return to IDLE.
  - Data bits are sampled every DIV thereafter.
  - STOP sample = 1: push the byte. STOP sample = 0: discard the byte and set `frame_err`.
  - Push to a full RX FIFO: byte dropped, `rx_overrun` set.
- Simultaneous events:
  - FIFO push and pop in the same cycle both take effect, including when the FIFO is full.
  - A DATA read in the same cycle that RX pushes into an empty FIFO returns 0; the pushed byte remains.
  - A STATUS read in the same cycle a sticky bit sets: the read shows the old value, and the bit is left set.
  - A DIV write takes effect at the next bit boundary of each FSM.
- Reset (at any time, including mid-frame):
  - Both FIFOs empty; DIV=`DIV_RESET`; sticky bits 0.
  - Both FSMs return to IDLE; `txd`=1; `rdata`=0.

## Timing
- Read latency: 1 cycle. `rdata` is registered on the `ren` cycle and valid on the next cycle. It holds its value when `ren`=0.
- Read side effects (pop, sticky clear) occur on the same edge that registers `rdata`.
- Writes commit on the `wen` edge. A DATA write makes `tx_empty`=0 in the next cycle.
- TX: `txd` falls at most 2 cycles after a push into an empty FIFO while IDLE. A frame lasts 10×DIV cycles.
- RX: a byte becomes visible (`rx_valid`=1) 2 (sync) + 9.5×DIV + 1 cycles after the `rxd` falling edge.

## Structure
- Shared package `uart_pkg`:
  - register offsets `UART_DATA`, `UART_STATUS`, `UART_DIV`;
  - STATUS bit indices;
  - FSM state enum `uart_state_t` {IDLE, START, DATA, STOP}.
- One sub-module, `sync_fifo` (parameters WIDTH, DEPTH; ports push/pop/full/empty/head), instantiated twice.
- Bit-timing counters and both FSMs live in `uart_periph`.

## Test plan
- Reset, then read STATUS → `rdata` = 0x02 one cycle later; `txd`=1.
- DIV=4; write 0x55 to DATA → `txd` shows start 0, then 1,0,1,0,1,0,1,0, stop 1, each bit 4 cycles; `tx_busy` falls after 40 cycles.
- Nine DATA writes (depth 8, DIV large) → first byte is popped into the shifter, the remaining 8 fill the FIFO; `tx_full`=1; the tenth write is dropped. The transmitted sequence matches the first nine bytes.
- Drive 0xA3 on `rxd` at DIV=8 → `rx_valid`=1; DATA read returns 0xA3; the next DATA read returns 0 with `rx_valid`=0.
- Receive 9 frames with no reads → `rx_overrun`=1; a STATUS read shows bit3, and a second STATUS read shows bit3=0.
- Frame with stop bit 0 → no push, `frame_err`=1. Assert `rst` mid-TX-frame → `txd`=1 the next cycle and the FIFOs are empty.
